window_tap_dispatcher: RTL and testbench

- Consumer end of the double-banked 5x5x16 window FIFO.
- Accepts one full window (25 taps x 16 channels x 14 bit) when the FIFO asserts data_valid, and serialises it tap-by-tap to the PE array over a valid/ready stream.
- Returns EX_Window_Done to the FIFO once the window is fully consumed.
- Tags the last tap of the last window in a depth so downstream accumulators can close out.

---
 rtl/window_tap_dispatcher_pkg.sv | 21 ++
 rtl/window_tap_dispatcher_mux.sv | 32 +++
 rtl/window_tap_dispatcher.sv | 161 ++++++++++++++++
 tb/tb_window_tap_dispatcher.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/window_tap_dispatcher_pkg.sv
// Shared constants and types for the 5x5x16 window path. fifox5x16, its banked
// wrapper and window_tap_dispatcher all import this package, so the window
// geometry is defined in one place.
package window_tap_dispatcher_pkg;

   localparam int unsigned DATA_W   = 14;            // bits per signed channel sample
   localparam int unsigned CH       = 16;            // channels per tap
   localparam int unsigned K        = 5;             // kernel edge
   localparam int unsigned TAPS     = K * K;         // taps per window
   localparam int unsigned TAP_W    = CH * DATA_W;   // one tap, all channels
   localparam int unsigned WIN_W    = TAPS * TAP_W;  // one full window
   localparam int unsigned IDX_W    = 5;             // tap index width, holds up to 32 taps
   localparam int unsigned LAST_IDX = TAPS - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/window_tap_dispatcher_mux.sv
// Combinational TAPS:1 tap slice select. With DISPATCH_ZERO_SKIP_EN defined it
// also flags a selected tap whose channels are all zero.
// Ports:
//   win_i     : window to select from
//   sel_i     : tap index; out-of-range indices return zero
//   slice_c_o : selected tap (combinational)
//   zero_c_o  : selected tap is all zero (DISPATCH_ZERO_SKIP_EN only)
module window_tap_mux
   import window_tap_dispatcher_pkg::*;
(
   input  logic [WIN_W-1:0] win_i,
   input  logic [IDX_W-1:0] sel_i,
   output logic [TAP_W-1:0] slice_c_o
`ifdef DISPATCH_ZERO_SKIP_EN
   ,
   output logic             zero_c_o
`endif
);

   // One-hot style select so an out-of-range index yields zero instead of an X slice.
   always_comb begin
      slice_c_o = '0;
      for (int unsigned t = 0; t < TAPS; t++) begin
         if (sel_i == IDX_W'(t)) slice_c_o = win_i[t*TAP_W +: TAP_W];
      end
   end

`ifdef DISPATCH_ZERO_SKIP_EN
   assign zero_c_o = (slice_c_o == '0);
`endif

endmodule

// File: rtl/window_tap_dispatcher.sv
// Consumer end of the double-banked window FIFO. Captures one window, streams
// its taps to the PE array over valid/ready, then pulses ex_window_done_o.
// Optional build macro: DISPATCH_ZERO_SKIP_EN (skip all-zero taps except the last).
// Ports:
//   clk, rst             : clock, async active-low reset
//   win_valid_i          : FIFO data_valid
//   win_data_i           : window, tap t at [t*TAP_W +: TAP_W]
//   win_depth_done_i     : FIFO depth_window_done, captured with the window
//   ex_window_done_o     : one-cycle pulse when the window is consumed
//   tap_valid_o/ready_i  : tap stream handshake
//   tap_data_o           : current tap
//   tap_idx_o            : current tap index
//   tap_last_o           : last tap of window
//   tap_depth_last_o     : last tap of a depth-closing window
//   win_cnt_o            : windows completed in current depth
module window_tap_dispatcher
   import window_tap_dispatcher_pkg::*;
#(
   parameter int unsigned CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             win_valid_i,
   input  logic [WIN_W-1:0] win_data_i,
   input  logic             win_depth_done_i,
   output logic             ex_window_done_o,
   output logic             tap_valid_o,
   input  logic             tap_ready_i,
   output logic [TAP_W-1:0] tap_data_o,
   output logic [IDX_W-1:0] tap_idx_o,
   output logic             tap_last_o,
   output logic             tap_depth_last_o,
   output logic [CNT_W-1:0] win_cnt_o
);

   state_e             state_q, state_d;
   logic [WIN_W-1:0]   win_q, win_d;
   logic               depth_q, depth_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               valid_q, valid_d;
   logic [TAP_W-1:0]   data_q, data_d;
   logic               last_q, last_d;
   logic               dlast_q, dlast_d;
   logic               done_q, done_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [WIN_W-1:0]   mux_src_c;
   logic [IDX_W-1:0]   mux_sel_c;
   logic [TAP_W-1:0]   slice_c;
   logic               tap_ok_c;

   // The mux looks ahead at the tap that becomes current next cycle, so tap_data
   // can be registered. In IDLE that is tap 0 of the incoming window.
   assign mux_src_c = (state_q == IDLE) ? win_data_i : win_q;
   assign mux_sel_c = (state_q == SEND) ? IDX_W'(idx_q + IDX_W'(1)) : '0;

`ifdef DISPATCH_ZERO_SKIP_EN
   logic zero_c;

   window_tap_mux u_mux (
      .win_i     (mux_src_c),
      .sel_i     (mux_sel_c),
      .slice_c_o (slice_c),
      .zero_c_o  (zero_c)
   );

   // The last tap is always presented so tap_last keeps its meaning.
   assign tap_ok_c = !zero_c || (mux_sel_c == IDX_W'(LAST_IDX));
`else
   window_tap_mux u_mux (
      .win_i     (mux_src_c),
      .sel_i     (mux_sel_c),
      .slice_c_o (slice_c)
   );

   assign tap_ok_c = 1'b1;
`endif

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         win_q   <= '0;
         depth_q <= 1'b0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         dlast_q <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         depth_q <= depth_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
         dlast_q <= dlast_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      depth_d = depth_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      data_d  = data_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (win_valid_i) begin
               state_d = SEND;
               win_d   = win_data_i;
               depth_d = win_depth_done_i;
               idx_d   = '0;
               data_d  = slice_c;
               valid_d = tap_ok_c;
            end
         end
         SEND: begin
            // A low valid_q here means the current tap is being skipped.
            if (!valid_q || tap_ready_i) begin
               if (valid_q && (idx_q == IDX_W'(LAST_IDX))) begin
                  state_d = DONE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d   = mux_sel_c;
                  data_d  = slice_c;
                  valid_d = tap_ok_c;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = depth_q ? '0 : CNT_W'(cnt_q + CNT_W'(1));
         end
         default: state_d = IDLE;
      endcase

      last_d  = valid_d && (idx_d == IDX_W'(LAST_IDX));
      dlast_d = last_d && depth_d;
   end

   assign ex_window_done_o = done_q;
   assign tap_valid_o      = valid_q;
   assign tap_data_o       = data_q;
   assign tap_idx_o        = idx_q;
   assign tap_last_o       = last_q;
   assign tap_depth_last_o = dlast_q;
   assign win_cnt_o        = cnt_q;

endmodule

// File: tb/tb_window_tap_dispatcher.sv
// Directed self-checking bench for window_tap_dispatcher.
`timescale 1ns/1ps
module tb_window_tap_dispatcher;
   import window_tap_dispatcher_pkg::*;

   localparam int unsigned CNT_W = 12;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             win_valid = 1'b0;
   logic [WIN_W-1:0] win_data = '0;
   logic             win_depth_done = 1'b0;
   logic             ex_window_done;
   logic             tap_valid;
   logic             tap_ready = 1'b0;
   logic [TAP_W-1:0] tap_data;
   logic [IDX_W-1:0] tap_idx;
   logic             tap_last;
   logic             tap_depth_last;
   logic [CNT_W-1:0] win_cnt;

   int checks = 0;
   int errors = 0;

   window_tap_dispatcher #(.CNT_W(CNT_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .win_valid_i      (win_valid),
      .win_data_i       (win_data),
      .win_depth_done_i (win_depth_done),
      .ex_window_done_o (ex_window_done),
      .tap_valid_o      (tap_valid),
      .tap_ready_i      (tap_ready),
      .tap_data_o       (tap_data),
      .tap_idx_o        (tap_idx),
      .tap_last_o       (tap_last),
      .tap_depth_last_o (tap_depth_last),
      .win_cnt_o        (win_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Tap t, channel c carries base + t*16 + c, truncated to the sample width.
   function automatic logic [TAP_W-1:0] exp_tap(input int base, input int t);
      logic [TAP_W-1:0] v;
      v = '0;
      for (int c = 0; c < CH; c++) v[c*DATA_W +: DATA_W] = DATA_W'(base + t*CH + c);
      return v;
   endfunction

   function automatic logic [WIN_W-1:0] make_win(input int base);
      logic [WIN_W-1:0] w;
      w = '0;
      for (int t = 0; t < TAPS; t++) w[t*TAP_W +: TAP_W] = exp_tap(base, t);
      return w;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, tap_valid, 0);
      check({tag, "_done"},  ex_window_done, 0);
      check({tag, "_idx"},   tap_idx, 0);
      check({tag, "_data"},  tap_data, 0);
      check({tag, "_last"},  tap_last, 0);
      check({tag, "_dlast"}, tap_depth_last, 0);
      check({tag, "_cnt"},   win_cnt, 0);
   endtask

   // One window with tap_ready held high; optionally keeps win_valid high and
   // changes win_data while the window is being sent.
   task automatic run_win(input int base, input bit depth, input bit hold, input int cnt_after);
      win_data       = make_win(base);
      win_depth_done = depth;
      win_valid      = 1'b1;
      tap_ready      = 1'b1;
      step();
      if (hold) win_data = make_win(base + 7);
      else      win_valid = 1'b0;
      for (int t = 0; t < TAPS; t++) begin
         check("tap_valid", tap_valid, 1);
         check("tap_idx", tap_idx, t);
         check("tap_data", tap_data, exp_tap(base, t));
         check("tap_last", tap_last, (t == TAPS - 1));
         check("tap_depth_last", tap_depth_last, (t == TAPS - 1) && depth);
         check("no_early_done", ex_window_done, 0);
         step();
      end
      check("ex_window_done", ex_window_done, 1);
      check("valid_in_done", tap_valid, 0);
      step();
      win_valid = 1'b0;
      check("done_one_cycle", ex_window_done, 0);
      check("win_cnt", win_cnt, cnt_after);
      check("no_recapture", tap_valid, 0);
      step();
      check("still_idle", tap_valid, 0);
   endtask

   int               hs;
   int               cyc;
   bit               seen_done;
   bit               prev_stall;
   logic [TAP_W-1:0] prev_data;
   logic [IDX_W-1:0] prev_idx;
   logic [WIN_W-1:0] zw;
   int               elist [4] = '{0, 1, 2, 24};

   initial begin
      // Reset values.
      repeat (2) step();
      check_all_zero("reset");
      rst = 1'b1;
      step();

      // Single window, full throughput.
      run_win(0, 1'b0, 1'b0, 1);

      // Backpressure: ready pattern 1,0,0,1.
      win_data = make_win(100); win_depth_done = 1'b0; win_valid = 1'b1; tap_ready = 1'b1;
      step();
      win_valid = 1'b0;
      hs = 0; cyc = 0; seen_done = 1'b0; prev_stall = 1'b0;
      while (!seen_done && cyc < 200) begin
         if (ex_window_done) begin
            seen_done = 1'b1;
         end else begin
            if (prev_stall) begin
               check("bp_hold_data", tap_data, prev_data);
               check("bp_hold_idx", tap_idx, prev_idx);
            end
            if (tap_valid) begin
               check("bp_idx", tap_idx, hs);
               check("bp_data", tap_data, exp_tap(100, hs));
            end
            tap_ready  = (cyc % 4 == 0) || (cyc % 4 == 3);
            prev_stall = tap_valid && !tap_ready;
            prev_data  = tap_data;
            prev_idx   = tap_idx;
            if (tap_valid && tap_ready) hs++;
            cyc++;
            step();
         end
      end
      check("bp_done_seen", seen_done, 1);
      check("bp_handshakes", hs, 25);
      tap_ready = 1'b1;
      step();
      check("bp_win_cnt", win_cnt, 2);

      // Depth close on the third window.
      run_win(200, 1'b0, 1'b0, 3);
      run_win(300, 1'b0, 1'b0, 4);
      run_win(400, 1'b1, 1'b0, 0);

      // win_valid held through SEND/DONE with data changing mid-window.
      run_win(500, 1'b0, 1'b1, 1);

      // Reset in the middle of a window.
      win_data = make_win(600); win_depth_done = 1'b0; win_valid = 1'b1; tap_ready = 1'b1;
      step();
      win_valid = 1'b0;
      repeat (12) step();
      check("mid_idx", tap_idx, 12);
      rst = 1'b0;
      #1;
      check_all_zero("mid_reset");
      for (int i = 0; i < 3; i++) begin
         step();
         check("mid_no_done", ex_window_done, 0);
         check("mid_no_valid", tap_valid, 0);
      end
      rst = 1'b1;
      step();
      run_win(700, 1'b0, 1'b0, 1);

`ifdef DISPATCH_ZERO_SKIP_EN
      // Taps 3..23 all zero are skipped.
      zw = make_win(800);
      for (int t = 3; t <= 23; t++) zw[t*TAP_W +: TAP_W] = '0;
      win_data = zw; win_depth_done = 1'b0; win_valid = 1'b1; tap_ready = 1'b1;
      step();
      win_valid = 1'b0;
      hs = 0; cyc = 0; seen_done = 1'b0;
      while (!seen_done && cyc < 100) begin
         if (ex_window_done) begin
            seen_done = 1'b1;
         end else begin
            if (tap_valid) begin
               check("zs_idx", tap_idx, (hs < 4) ? elist[hs] : 99);
               check("zs_data", tap_data, exp_tap(800, (hs < 4) ? elist[hs] : 0));
               check("zs_last", tap_last, (hs == 3));
               hs++;
            end
            cyc++;
            step();
         end
      end
      check("zs_done_seen", seen_done, 1);
      check("zs_emitted", hs, 4);
      step();
      check("zs_win_cnt", win_cnt, 2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
